// File: rtl/mux8_rr_arbiter.sv
`timescale 1ns/1ps
// mux8_rr_arbiter
// Round-robin arbiter and select sequencer for an 8:1 one-bit mux datapath.
// One requester owns the shared output at a time. An owner keeps the grant
// for at most MAX_HOLD consecutive cycles, and then the next requester in
// rotating priority order gets the grant.
//
// Optional feature: define MUX8_ARB_LOCK_EN to add lock_i. While OWNED and
// lock_i=1, the hold-limit release is suppressed and the owner keeps the
// grant until its request drops.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   lock_i   - (MUX8_ARB_LOCK_EN only) suppress the hold-limit release
//   req_i    - request bit per requester
//   din_i    - data bit per requester (bit k belongs to requester k)
//   grant_o  - registered one-hot (or zero) grant to the current owner
//   sel_o    - registered index of the current or most recent owner
//   busy_o   - registered, high while a grant is active
//   dout_o   - combinational: din_i[sel_o] when busy, else 0
module mux8_rr_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
`ifdef MUX8_ARB_LOCK_EN
    input  logic         lock_i,
`endif
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] din_i,
    output logic [N-1:0] grant_o,
    output logic [2:0]   sel_o,
    output logic         busy_o,
    output logic         dout_o
);

    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic               lock_c;
    logic               at_max;
    logic               release_c;

`ifdef MUX8_ARB_LOCK_EN
    assign lock_c = lock_i;
`else
    assign lock_c = 1'b0;
`endif

    // Rotating-priority search: last+1 .. last+8 (mod 8); the previous owner
    // is examined last, so it only wins when nobody else is requesting.
    always_comb begin
        logic [SEL_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = SEL_W'(last_q + SEL_W'(i));
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign at_max    = (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign release_c = !req_i[sel_q] || (at_max && !lock_c);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d    = ST_OWNED;
                    grant_d    = N'(1) << win_idx;
                    sel_d      = win_idx;
                    busy_d     = 1'b1;
                    last_d     = win_idx;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            ST_OWNED: begin
                if (!release_c) begin
                    // Saturates only when lock has suppressed the limit.
                    if (!at_max) begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end else if (win_found) begin
                    // Hand over at this same edge; no idle gap.
                    grant_d    = N'(1) << win_idx;
                    sel_d      = win_idx;
                    last_d     = win_idx;
                    hold_cnt_d = CNT_W'(1);
                end else begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            last_q     <= SEL_W'(N - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant_o = grant_q;
    assign sel_o   = sel_q;
    assign busy_o  = busy_q;
    assign dout_o  = busy_q & din_i[sel_q];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mux8_rr_arbiter. Expected output tuples are queued
// as stimulus is driven and popped when the outputs are sampled.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       dout;
`ifdef MUX8_ARB_LOCK_EN
    logic       lock;
`endif

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic       dout;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    mux8_rr_arbiter dut (
`ifdef MUX8_ARB_LOCK_EN
        .lock_i  (lock),
`endif
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req),
        .din_i   (din),
        .grant_o (grant),
        .sel_o   (sel),
        .busy_o  (busy),
        .dout_o  (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse reset and leave inputs idle; returns 1 time unit after an edge.
    task automatic do_reset();
        req = 8'h00;
        din = 8'h00;
`ifdef MUX8_ARB_LOCK_EN
        lock = 1'b0;
`endif
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t got;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) rst_n = 1'b1;
            e = '{8'h00, 3'd0, 1'b0, 1'b0};
            exp_q.push_back(e);
            if (c > 0) begin
                @(posedge clk); #1;
            end
            e   = exp_q.pop_front();
            got = '{grant, sel, busy, dout};
            checks++;
            if (got !== e)
                $display("FAIL reset cyc%0d: got g=%h s=%0d b=%b d=%b want g=%h s=%0d b=%b d=%b",
                         c, grant, sel, busy, dout, e.grant, e.sel, e.busy, e.dout);
            else passed++;
        end
    endtask

    task automatic test_single_regrant();
        exp_t e;
        exp_t got;
        do_reset();
        req = 8'h04;
        din = 8'h04;
        for (int c = 1; c <= 12; c++) begin
            if (c == 11) req = 8'h00;
            if (c <= 10) e = '{8'h04, 3'd2, 1'b1, 1'b1};
            else         e = '{8'h00, 3'd2, 1'b0, 1'b0};
            exp_q.push_back(e);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = '{grant, sel, busy, dout};
            checks++;
            if (got !== e)
                $display("FAIL single_regrant cyc%0d: got g=%h s=%0d b=%b d=%b want g=%h s=%0d b=%b d=%b",
                         c, grant, sel, busy, dout, e.grant, e.sel, e.busy, e.dout);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        exp_t got;
        int   o;
        do_reset();
        req = 8'hFF;
        din = 8'hA5;
        for (int c = 1; c <= 36; c++) begin
            o = ((c - 1) / 4) % 8;
            e = '{8'(1) << o, 3'(o), 1'b1, din[o]};
            exp_q.push_back(e);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = '{grant, sel, busy, dout};
            checks++;
            if (got !== e)
                $display("FAIL round_robin cyc%0d: got g=%h s=%0d b=%b d=%b want g=%h s=%0d b=%b d=%b",
                         c, grant, sel, busy, dout, e.grant, e.sel, e.busy, e.dout);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        exp_t got;
        do_reset();
        req = 8'h80;
        din = 8'h81;
        for (int c = 1; c <= 9; c++) begin
            if (c == 2) req = 8'h81;
            if (c >= 5 && c <= 8) e = '{8'h01, 3'd0, 1'b1, 1'b1};
            else                  e = '{8'h80, 3'd7, 1'b1, 1'b1};
            exp_q.push_back(e);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = '{grant, sel, busy, dout};
            checks++;
            if (got !== e)
                $display("FAIL wrap cyc%0d: got g=%h s=%0d b=%b d=%b want g=%h s=%0d b=%b d=%b",
                         c, grant, sel, busy, dout, e.grant, e.sel, e.busy, e.dout);
            else passed++;
        end
    endtask

    task automatic test_owner_drop();
        exp_t e;
        exp_t got;
        do_reset();
        req = 8'h21;
        din = 8'h20;
        // Cycles 1-4 clocked, 5-6 combinational dout checks, 7 clocked release.
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) req = 8'h20;
            if (c == 5) din = 8'h00;
            if (c == 6) din = 8'h20;
            if (c == 7) req = 8'h00;
            if (c <= 2)      e = '{8'h01, 3'd0, 1'b1, 1'b0};
            else if (c == 5) e = '{8'h20, 3'd5, 1'b1, 1'b0};
            else if (c == 7) e = '{8'h00, 3'd5, 1'b0, 1'b0};
            else             e = '{8'h20, 3'd5, 1'b1, 1'b1};
            exp_q.push_back(e);
            if (c == 5 || c == 6) #1;
            else begin
                @(posedge clk); #1;
            end
            e   = exp_q.pop_front();
            got = '{grant, sel, busy, dout};
            checks++;
            if (got !== e)
                $display("FAIL owner_drop step%0d: got g=%h s=%0d b=%b d=%b want g=%h s=%0d b=%b d=%b",
                         c, grant, sel, busy, dout, e.grant, e.sel, e.busy, e.dout);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_grant();
        exp_t e;
        exp_t got;
        do_reset();
        req = 8'h08;
        din = 8'hFF;
        // Steps 1-2 clocked grant, 3 async reset, 4 reset across edge, 5 restart.
        for (int c = 1; c <= 5; c++) begin
            if (c <= 2)      e = '{8'h08, 3'd3, 1'b1, 1'b1};
            else if (c <= 4) e = '{8'h00, 3'd0, 1'b0, 1'b0};
            else             e = '{8'h08, 3'd3, 1'b1, 1'b1};
            exp_q.push_back(e);
            if (c == 3) begin
                #2 rst_n = 1'b0;
                #1;
            end else begin
                if (c == 5) begin
                    rst_n = 1'b1;
                    req   = 8'h18;
                end
                @(posedge clk); #1;
            end
            e   = exp_q.pop_front();
            got = '{grant, sel, busy, dout};
            checks++;
            if (got !== e)
                $display("FAIL reset_mid_grant step%0d: got g=%h s=%0d b=%b d=%b want g=%h s=%0d b=%b d=%b",
                         c, grant, sel, busy, dout, e.grant, e.sel, e.busy, e.dout);
            else passed++;
        end
    endtask

`ifdef MUX8_ARB_LOCK_EN
    task automatic test_lock();
        exp_t e;
        exp_t got;
        do_reset();
        lock = 1'b1;
        req  = 8'h03;
        din  = 8'h02;
        for (int c = 1; c <= 11; c++) begin
            if (c == 11) lock = 1'b0;
            if (c <= 10) e = '{8'h01, 3'd0, 1'b1, 1'b0};
            else         e = '{8'h02, 3'd1, 1'b1, 1'b1};
            exp_q.push_back(e);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = '{grant, sel, busy, dout};
            checks++;
            if (got !== e)
                $display("FAIL lock cyc%0d: got g=%h s=%0d b=%b d=%b want g=%h s=%0d b=%b d=%b",
                         c, grant, sel, busy, dout, e.grant, e.sel, e.busy, e.dout);
            else passed++;
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        din   = 8'h00;
`ifdef MUX8_ARB_LOCK_EN
        lock  = 1'b0;
`endif
        test_reset();
        test_single_regrant();
        test_round_robin();
        test_wrap();
        test_owner_drop();
        test_reset_mid_grant();
`ifdef MUX8_ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and select sequencer for an 8:1 one-bit multiplexer datapath.
- Eight requesters compete for the shared output.
- The block grants one requester at a time and drives a registered 3-bit select.
- It routes the winner's data bit to the shared output.
- The hold-time limit keeps any one requester from monopolising the mux.

Parameters:
- N, 8: number of requesters. Fixed at 8; the select is 3 bits wide.
- MAX_HOLD, 4: maximum consecutive cycles one owner keeps the grant. Legal range 1..15.

Ports:
- clk: input, 1. Single clock; all state updates on the rising edge.
- rst_n: input, 1. Asynchronous, active-low reset.
- req: input, 8. Request bit per requester.
- din: input, 8. Data bit per requester; bit k belongs to requester k.
- grant: output, 8. Registered, one-hot or zero; current owner.
- sel: output, 3. Registered binary index of the current or most recent owner.
- busy: output, 1. Registered; high while any grant is active.
- dout: output, 1. Combinational. Equals din[sel] when busy, else 0.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - grant=0, sel=0, busy=0, dout=0.
  - Internal round-robin pointer last=7, so the first search starts at requester 0.
  - Internal hold_cnt=0.
- Reset asserted mid-grant clears all of the above immediately, without waiting for clk.
- States: IDLE (busy=0) and OWNED (busy=1).
- Round-robin search order: last+1, last+2, ..., last+8 (mod 8). The first index with req high wins. The previous owner is therefore checked last.
- IDLE:
  - If req != 0 at an edge: grant=onehot(winner), sel=winner, busy=1, last=winner, hold_cnt=1. Go to OWNED.
  - Latency is one edge from the first sampled request to a visible grant.
  - If req == 0: remain in IDLE. sel holds its old value.
- OWNED: at each edge, evaluate release = (req[sel]==0) OR (hold_cnt==MAX_HOLD).
  - No release: hold_cnt increments and grant is unchanged.
  - Release with req != 0: run the search and grant the winner at this same edge (no idle gap). hold_cnt=1.
    - If only the previous owner is requesting, it is regranted with hold_cnt reloaded to 1.
    - grant stays high continuously in that case.
  - Release with req == 0: grant=0, busy=0. Go to IDLE. sel and last hold.
- An owner therefore holds the grant for at most MAX_HOLD consecutive cycles before another requester gets a chance.
- Simultaneous requests are resolved purely by rotating priority. No requester is starved.
- grant is never multi-hot. sel always equals the index of the set grant bit while busy=1.
- Request bits of non-owners have no effect while OWNED unless a release occurs.
- hold_cnt is 4 bits wide and never exceeds MAX_HOLD.

Optional Feature:
Macro: MUX8_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While OWNED and lock=1, the hold_cnt==MAX_HOLD release term is suppressed and hold_cnt saturates at MAX_HOLD.
  - The owner keeps the grant until its req drops.
  - lock has no effect in IDLE.
- Undefined: no lock port exists, and the MAX_HOLD limit always applies.

Test Plan:
1. Reset, then req=0 for 5 cycles -> grant=0, busy=0, sel=0, dout=0 throughout.
2. req=0x04 held, din=0x04 -> one edge later grant=0x04, sel=2, busy=1, dout=1. grant stays 0x04 continuously past 4 cycles (regrant), with no busy drop.
3. req=0xFF constant -> grant sequence 0x01, 0x02, 0x04, ..., 0x80, 0x01. Each grant lasts exactly 4 cycles and changes with no gap cycle.
4. Owner 7 granted with req=0x81; hold for 4 cycles -> next grant is 0x01 (wrap from 7 to 0), sel=0.
5. req=0x21 from IDLE -> grant 0x01. Drop req[0] after 2 cycles -> grant 0x20 at the next edge, sel=5, dout follows din[5].
6. rst_n low mid-grant on requester 3 -> grant=0, busy=0 before the next clk edge. After release, with req=0x18, the first grant is 0x08 (search restarts at 0).
7. (MUX8_ARB_LOCK_EN) req=0x03, lock=1 with owner 0 -> grant 0x01 held for 10 cycles. Drop lock -> owner releases at the next edge and grant=0x02.
